// File: rtl/bextdep_seq.sv
// Iterative bit-extract (BEXT) / bit-deposit (BDEP) unit: one mask bit per cycle,
// valid/ready handshake on request and result sides.
module bextdep_seq #(
    parameter int XLEN       = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_op,
    input  logic [XLEN-1:0] din1,
    input  logic [XLEN-1:0] din2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dout,
    output logic            busy
);

    localparam int IW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] d_q, m_q, r_q, r_nxt;
    logic            op_q;
    logic [IW-1:0]   i_q, j_q;
    logic            accept, start_done, last;

    assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    // A zero mask only short-circuits when the scan is allowed to stop early.
    assign start_done = EARLY_EXIT && (din2 == '0);
    assign last       = EARLY_EXIT ? ((m_q >> 1) == '0) : (i_q == IW'(XLEN - 1));
    assign out_valid  = (state == DONE);
    assign busy       = (state == BUSY);

    always_comb begin
        r_nxt = r_q;
        if (m_q[0]) begin
            if (op_q)
                r_nxt[i_q] = d_q[j_q];
            else
                r_nxt[j_q] = d_q[i_q];
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = start_done ? DONE : BUSY;
        end else begin
            case (state)
                BUSY:    if (last) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            d_q   <= '0;
            m_q   <= '0;
            r_q   <= '0;
            op_q  <= 1'b0;
            i_q   <= '0;
            j_q   <= '0;
            dout  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                d_q  <= din1;
                m_q  <= din2;
                op_q <= in_op;
                r_q  <= '0;
                i_q  <= '0;
                j_q  <= '0;
                if (start_done)
                    dout <= '0;
            end else if (state == BUSY) begin
                r_q <= r_nxt;
                m_q <= m_q >> 1;
                i_q <= i_q + IW'(1);
                if (m_q[0])
                    j_q <= j_q + IW'(1);
                // dout only moves when a result enters DONE.
                if (last)
                    dout <= r_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bextdep_seq.sv
// Bench for bextdep_seq: instance 0 uses EARLY_EXIT=1, instance 1 uses EARLY_EXIT=0,
// both checked every cycle against a transaction-level model.
module tb_bextdep_seq;

    logic        clk = 1'b0;
    logic        resetn    [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        in_op     [2];
    logic [31:0] din1      [2];
    logic [31:0] din2      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] dout      [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bextdep_seq #(.XLEN(32), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .resetn(resetn[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_op(in_op[0]), .din1(din1[0]), .din2(din2[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .dout(dout[0]), .busy(busy[0]));

    bextdep_seq #(.XLEN(32), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .resetn(resetn[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_op(in_op[1]), .din1(din1[1]), .din2(din2[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .dout(dout[1]), .busy(busy[1]));

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_bext(input logic [31:0] x, input logic [31:0] m);
        logic [31:0] r = '0;
        int j = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) begin r[j] = x[i]; j++; end
        return r;
    endfunction

    function automatic logic [31:0] m_bdep(input logic [31:0] x, input logic [31:0] m);
        logic [31:0] r = '0;
        int j = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) begin r[i] = x[j]; j++; end
        return r;
    endfunction

    function automatic int m_lat(input int k, input logic [31:0] m);
        int h = -1;
        if (k == 1) return 33;
        for (int i = 0; i < 32; i++) if (m[i]) h = i;
        return (h < 0) ? 1 : h + 2;
    endfunction

    // Transaction-level model: 0 idle, 1 computing, 2 result held.
    int          ms   [2];
    int          cnt  [2];
    logic [31:0] pend [2];
    logic [31:0] last_d [2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn[k]) begin
                ms[k] = 0; cnt[k] = 0; last_d[k] = '0;
                chk("rst_out_valid", k, 64'(out_valid[k]), 64'd0);
                chk("rst_dout", k, 64'(dout[k]), 64'd0);
                chk("rst_busy", k, 64'(busy[k]), 64'd0);
            end else begin
                bit free;
                chk("out_valid", k, 64'(out_valid[k]), 64'(ms[k] == 2));
                chk("dout", k, 64'(dout[k]), 64'(last_d[k]));
                chk("busy", k, 64'(busy[k]), 64'(ms[k] == 1));
                free = (ms[k] == 0) || (ms[k] == 2 && out_ready[k]);
                chk("in_ready", k, 64'(in_ready[k]), 64'(free));
                if (ms[k] == 2 && out_ready[k]) begin
                    if (k == 0) q0.push_back(last_d[k]); else q1.push_back(last_d[k]);
                    ms[k] = 0;
                end else if (ms[k] == 1) begin
                    cnt[k]--;
                    if (cnt[k] == 0) begin ms[k] = 2; last_d[k] = pend[k]; end
                end
                if (in_valid[k] && free) begin
                    int lat;
                    pend[k] = in_op[k] ? m_bdep(din1[k], din2[k]) : m_bext(din1[k], din2[k]);
                    lat = m_lat(k, din2[k]);
                    if (lat == 1) begin ms[k] = 2; last_d[k] = pend[k]; end
                    else begin ms[k] = 1; cnt[k] = lat - 1; end
                end
            end
        end
    end

    task automatic req(input int k, input bit op, input logic [31:0] a, input logic [31:0] m);
        int t = 0;
        in_valid[k] = 1'b1; in_op[k] = op; din1[k] = a; din2[k] = m;
        @(negedge clk);
        while (!in_ready[k] && t < 200) begin @(negedge clk); t++; end
        if (!in_ready[k]) chk("accept_timeout", k, 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0; in_op[k] = 1'($urandom); din1[k] = $urandom; din2[k] = $urandom;
    endtask

    task automatic get_result(input int k, input bit bp, output logic [31:0] r);
        int t = 0;
        while (((k == 0) ? q0.size() : q1.size()) == 0 && t < 400) begin
            @(posedge clk); #1;
            out_ready[k] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            t++;
        end
        if (((k == 0) ? q0.size() : q1.size()) == 0) begin
            chk("result_timeout", k, 64'd0, 64'd1);
            r = 'x;
        end else begin
            r = (k == 0) ? q0.pop_front() : q1.pop_front();
        end
    endtask

    task automatic do_op(input int k, input bit op, input logic [31:0] a, input logic [31:0] m,
                         input bit bp, output logic [31:0] r);
        req(k, op, a, m);
        get_result(k, bp, r);
    endtask

    task automatic lat_op(input int k, input bit op, input logic [31:0] a, input logic [31:0] m,
                          output logic [31:0] r, output int lat);
        out_ready[k] = 1'b1;
        req(k, op, a, m);
        lat = 1;
        while (!out_valid[k] && lat < 100) begin @(posedge clk); #1; lat++; end
        get_result(k, 1'b0, r);
    endtask

    function automatic logic [31:0] pick_mask();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom & $urandom & $urandom;
            2:       return $urandom >> $urandom_range(0, 31);
            default: return $urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic rt_loop(input int k, input int nv);
        logic [31:0] x, m, r1, r2, r3, r4, lowm;
        for (int n = 0; n < nv; n++) begin
            x = $urandom; m = pick_mask();
            lowm = 32'((64'd1 << $countones(m)) - 64'd1);
            do_op(k, 1'b0, x, m, 1'b1, r1);
            do_op(k, 1'b1, r1, m, 1'b1, r2);
            chk("rt_bdep_of_bext", k, 64'(r2), 64'(x & m));
            do_op(k, 1'b1, x, m, 1'b1, r3);
            do_op(k, 1'b0, r3, m, 1'b1, r4);
            chk("rt_bext_of_bdep", k, 64'(r4), 64'(x & lowm));
        end
    endtask

    typedef struct { bit op; logic [31:0] a; logic [31:0] m; logic [31:0] res; int lat1; } vec_t;
    vec_t dv[6];

    initial begin
        logic [31:0] r;
        int lat;
        for (int k = 0; k < 2; k++) begin
            resetn[k] = 1'b0; in_valid[k] = 1'b0; in_op[k] = 1'b0;
            din1[k] = '0; din2[k] = '0; out_ready[k] = 1'b1;
            ms[k] = 0; cnt[k] = 0; pend[k] = '0; last_d[k] = '0;
        end
        dv[0] = '{1'b0, 32'h1234_5678, 32'h0000_FF00, 32'h0000_0056, 17};
        dv[1] = '{1'b1, 32'h0000_00AB, 32'h0F0F_0000, 32'h0A0B_0000, 29};
        dv[2] = '{1'b0, 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000, 1};
        dv[3] = '{1'b1, 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000, 1};
        dv[4] = '{1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 33};
        dv[5] = '{1'b1, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000, 33};

        // Pin the model against hand-computed values.
        chk("pin_bext", 0, 64'(m_bext(32'h1234_5678, 32'h0000_FF00)), 64'h56);
        chk("pin_bdep", 0, 64'(m_bdep(32'h0000_00AB, 32'h0F0F_0000)), 64'h0A0B_0000);
        chk("pin_lat", 0, 64'(m_lat(0, 32'h0F0F_0000)), 64'd29);

        repeat (3) @(posedge clk);
        #1;
        resetn[0] = 1'b1; resetn[1] = 1'b1;
        #1;
        chk("reset_in_ready", 0, 64'(in_ready[0]), 64'd1);
        chk("reset_in_ready", 1, 64'(in_ready[1]), 64'd1);

        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 6; v++) begin
                lat_op(k, dv[v].op, dv[v].a, dv[v].m, r, lat);
                chk($sformatf("dir%0d_result", v), k, 64'(r), 64'(dv[v].res));
                chk($sformatf("dir%0d_latency", v), k, 64'(lat), (k == 0) ? 64'(dv[v].lat1) : 64'd33);
            end

        // Backpressure, then retire and accept in the same cycle.
        out_ready[0] = 1'b0;
        req(0, 1'b0, 32'h1234_5678, 32'h0000_FF00);
        for (int t = 0; t < 100 && !out_valid[0]; t++) begin @(posedge clk); #1; end
        repeat (5) @(posedge clk);
        #1;
        chk("bp_out_valid", 0, 64'(out_valid[0]), 64'd1);
        chk("bp_dout", 0, 64'(dout[0]), 64'h56);
        chk("bp_in_ready", 0, 64'(in_ready[0]), 64'd0);
        out_ready[0] = 1'b1;
        req(0, 1'b1, 32'h0000_00AB, 32'h0F0F_0000);
        chk("b2b_busy", 0, 64'(busy[0]), 64'd1);
        get_result(0, 1'b0, r);
        chk("b2b_first", 0, 64'(r), 64'h56);
        get_result(0, 1'b0, r);
        chk("b2b_second", 0, 64'(r), 64'h0A0B_0000);

        // Reset in the third busy cycle.
        req(0, 1'b1, 32'h5555_AAAA, 32'hFFFF_FFFF);
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn[0] = 1'b0;
        #1;
        chk("midrst_out_valid", 0, 64'(out_valid[0]), 64'd0);
        chk("midrst_dout", 0, 64'(dout[0]), 64'd0);
        chk("midrst_busy", 0, 64'(busy[0]), 64'd0);
        @(posedge clk); #1;
        resetn[0] = 1'b1;
        #1;
        chk("midrst_in_ready", 0, 64'(in_ready[0]), 64'd1);
        lat_op(0, 1'b0, 32'hF0F0_1234, 32'h00FF_00F0, r, lat);
        chk("midrst_next_result", 0, 64'(r), 64'(m_bext(32'hF0F0_1234, 32'h00FF_00F0)));
        chk("midrst_next_latency", 0, 64'(lat), 64'd25);

        fork
            rt_loop(0, 250);
            rt_loop(1, 250);
        join

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
